// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped console UART transmitter with result flags
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int          CLKS_PER_BIT = 4,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        tx,
    output logic        busy,
    output logic        done,
    output logic        pass
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [7:0]    shift_next;
    logic          ovf;
    logic          pop;
    logic          push;
    logic          tx_next;
    logic          empty;
    logic          full;
    logic          baud_last;
    logic          sel_tx;
    logic          sel_st;
    logic          sel_res;
    logic [2:0]    cnt_sat;
    state_t        state;
    state_t        state_next;

    assign sel_tx    = (DataAdr == BASE_ADDR);
    assign sel_st    = (DataAdr == BASE_ADDR + 32'd4);
    assign sel_res   = (DataAdr == BASE_ADDR + 32'd8);
    assign empty     = (count == '0);
    assign full      = (count == CW'(FIFO_DEPTH));
    assign baud_last = (baud == BW'(CLKS_PER_BIT - 1));
    // A store into a full FIFO still lands if the transmitter frees a slot the same cycle.
    assign push      = MemWrite && sel_tx && (!full || pop);
    assign busy      = (state != IDLE) || !empty;

    // FIFO pointers and occupancy; pointers wrap naturally since depth is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are meaningless while empty so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= WriteData[7:0];
    end

    // Transmitter state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Transmitter next-state: STOP chains straight into START when more bytes are queued.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!empty) state_next = START;
            START:   if (baud_last) state_next = DATA;
            DATA:    if (baud_last && bit_idx == 3'd7) state_next = STOP;
            STOP:    if (baud_last) state_next = empty ? IDLE : START;
            default: state_next = IDLE;
        endcase
    end

    // Transmitter outputs: pop decision, next shift value and the bit to register onto tx.
    always_comb begin
        pop        = ((state == IDLE) || (state == STOP && baud_last)) && !empty;
        shift_next = shift;
        if (pop)
            shift_next = mem[rptr];
        else if (state == DATA && baud_last)
            shift_next = {1'b0, shift[7:1]};
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    // Baud/bit counters, shift register and the glitch-free tx register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            if (state == IDLE || state_next != state || baud_last) baud <= '0;
            else                                                   baud <= baud + 1'b1;
            if (state != DATA) bit_idx <= '0;
            else if (baud_last) bit_idx <= bit_idx + 1'b1;
            shift <= shift_next;
            tx    <= tx_next;
        end
    end

    // Sticky overflow and result flags; an overflow in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf  <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
        end else begin
            if (MemWrite && sel_tx && full && !pop)        ovf <= 1'b1;
            else if (MemWrite && sel_st && WriteData[3])   ovf <= 1'b0;
            if (MemWrite && sel_res) begin
                done <= 1'b1;
                pass <= (WriteData == 32'd1);
            end
        end
    end

    // Status read path; only the STATUS address returns non-zero data.
    always_comb begin
        if (32'(count) > 32'd7) cnt_sat = 3'd7;
        else                    cnt_sat = 3'(count);
        ReadData = '0;
        if (sel_st) ReadData = {25'd0, cnt_sat, ovf, busy, empty, full};
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - directed self-checking bench for mmio_uart_tx
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] OUTA = 32'h2000_0000;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        tx;
    logic        busy;
    logic        done;
    logic        pass;

    int n_assert = 0;
    int n_fail   = 0;
    bit exp_q[$];

    mmio_uart_tx #(
        .BASE_ADDR(BASE),
        .CLKS_PER_BIT(4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .MemWrite(MemWrite),
        .DataAdr(DataAdr),
        .WriteData(WriteData),
        .ReadData(ReadData),
        .tx(tx),
        .busy(busy),
        .done(done),
        .pass(pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the store is sampled at the next posedge, returns at the following negedge.
    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        MemWrite  = 1'b1;
        DataAdr   = addr;
        WriteData = data;
        @(negedge clk);
        MemWrite  = 1'b0;
        DataAdr   = 32'd0;
        WriteData = 32'd0;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        DataAdr = addr;
        #1;
        chk(tag, ReadData, exp);
        DataAdr = 32'd0;
    endtask

    // One 8N1 frame at 4 clocks per bit, one entry per cycle.
    task automatic add_frame(input logic [7:0] b);
        for (int i = 0; i < 40; i++) begin
            int s;
            s = i / 4;
            if (s == 0)      exp_q.push_back(1'b0);
            else if (s == 9) exp_q.push_back(1'b1);
            else             exp_q.push_back(b[s-1]);
        end
    endtask

    // Samples tx once per negedge against the queued expectation, skipping already-elapsed cycles.
    task automatic capture(input int skip, input string tag);
        int mism;
        bit e;
        mism = 0;
        for (int i = 0; i < skip; i++) void'(exp_q.pop_front());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (tx !== e) mism++;
            @(negedge clk);
        end
        chk(tag, mism, 0);
    endtask

    initial begin
        int highs;
        reset     = 1'b0;
        MemWrite  = 1'b0;
        DataAdr   = 32'd0;
        WriteData = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        reset = 1'b1;
        @(negedge clk);
        rd(BASE + 4, 32'h2, "rst_status");

        // single frame 0x55
        store(BASE, 32'h55);
        chk("t1_busy", busy, 1);
        rd(BASE + 4, 32'h14, "t1_status");
        @(negedge clk);
        chk("t1_tx_start", tx, 0);
        add_frame(8'h55);
        capture(0, "t1_frame");
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_tx", tx, 1);

        // back-to-back 0x41, 0x42
        store(BASE, 32'h41);
        store(BASE, 32'h42);
        rd(BASE + 4, 32'h14, "t2_status_count1");
        add_frame(8'h41);
        add_frame(8'h42);
        capture(0, "t2_frames");
        chk("t2_idle_busy", busy, 0);

        // overflow: six stores into depth-4 FIFO
        for (int i = 1; i <= 6; i++) store(BASE, 32'(i));
        rd(BASE + 4, 32'h4D, "t3_status_full_ovf");
        store(BASE + 4, 32'h8);
        rd(BASE + 4, 32'h45, "t3_status_ovf_clr");
        for (int i = 1; i <= 5; i++) add_frame(8'(i));
        capture(5, "t3_frames");
        chk("t3_idle_busy", busy, 0);
        rd(BASE + 4, 32'h2, "t3_status_end");

        // result flags
        store(BASE + 8, 32'd1);
        chk("t4_done1", done, 1);
        chk("t4_pass1", pass, 1);
        store(BASE + 8, 32'd0);
        chk("t4_done2", done, 1);
        chk("t4_pass2", pass, 0);
        store(BASE + 12, 32'd1);
        chk("t4_done3", done, 1);
        chk("t4_pass3", pass, 0);
        chk("t4_busy3", busy, 0);
        rd(BASE + 12, 32'h0, "t4_rd_c");
        rd(BASE + 8, 32'h0, "t4_rd_8");

        // reset mid-frame with two bytes queued
        store(BASE, 32'h5A);
        store(BASE, 32'h11);
        store(BASE, 32'h22);
        rd(BASE + 4, 32'h24, "t5_status_q2");
        repeat (13) @(negedge clk);
        chk("t5_tx_mid", tx, 0);
        reset = 1'b0;
        #1;
        chk("t5_rst_tx", tx, 1);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", done, 0);
        rd(BASE + 4, 32'h2, "t5_rst_status");
        @(negedge clk);
        reset = 1'b1;
        highs = 0;
        for (int i = 0; i < 60; i++) begin
            if (tx === 1'b1) highs++;
            @(negedge clk);
        end
        chk("t5_no_frame", highs, 60);
        chk("t5_busy_after", busy, 0);
        rd(BASE + 4, 32'h2, "t5_status_after");

        // out-of-window read while busy
        store(BASE, 32'h0F);
        rd(OUTA, 32'h0, "t6_rd_out");
        rd(BASE, 32'h0, "t6_rd_0");
        rd(BASE + 4, 32'h14, "t6_status");
        @(negedge clk);
        add_frame(8'h0F);
        capture(0, "t6_frame");
        chk("t6_idle_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
